// File: rtl/hex_rx_pkg.sv
// hex_rx_pkg -- shared definitions for the hex_rx serial hex-word receiver.
//
// Contents:
//   SERIAL_WCNT     default clock cycles per serial bit
//   TERM_*          byte codes that terminate a hex word
//   rx_state_e      deframer FSM state encoding
//   char_kind_e     classification of a received byte
//   decode_char()   byte -> {kind, nibble}
//
// Build option: define HEX_RX_UPPER_EN to accept upper-case 'A'-'F' as hex
// digits. Without it those characters are illegal.

package hex_rx_pkg;

    localparam int SERIAL_WCNT = 16;

    localparam logic [7:0] TERM_SP = 8'h20;
    localparam logic [7:0] TERM_CR = 8'h0D;
    localparam logic [7:0] TERM_LF = 8'h0A;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    typedef enum logic [1:0] {
        CH_HEX     = 2'd0,
        CH_TERM    = 2'd1,
        CH_ILLEGAL = 2'd2
    } char_kind_e;

    typedef struct packed {
        char_kind_e kind;
        logic [3:0] nib;
    } char_dec_t;

    // Letters map via the low nibble: 'a' (0x61) and 'A' (0x41) both have
    // low nibble 1, so +9 gives 10.
    function automatic char_dec_t decode_char(input logic [7:0] c);
        char_dec_t r;
        r.kind = CH_ILLEGAL;
        r.nib  = 4'h0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r.kind = CH_HEX;
            r.nib  = c[3:0];
        end else if (c >= 8'h61 && c <= 8'h66) begin
            r.kind = CH_HEX;
            r.nib  = c[3:0] + 4'd9;
`ifdef HEX_RX_UPPER_EN
        end else if (c >= 8'h41 && c <= 8'h46) begin
            r.kind = CH_HEX;
            r.nib  = c[3:0] + 4'd9;
`endif
        end else if (c == TERM_SP || c == TERM_CR || c == TERM_LF) begin
            r.kind = CH_TERM;
        end
        return r;
    endfunction

endpackage

// File: rtl/hex_rx_uart_rx_byte.sv
// uart_rx_byte -- 8N1 serial deframer, LSB first, idle-high line.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_i         asynchronous active-high reset
//   rxd_i         raw serial line (synchronized internally)
//   byte_o        last accepted byte, valid while byte_valid_o is high
//   byte_valid_o  one-cycle pulse: byte_o holds a correctly framed byte
//   frame_err_o   one-cycle pulse: stop bit sampled low, byte dropped
//   state_o       current FSM state, for debug visibility
//
// Timing: a falling edge on the synchronized line starts a frame. The start
// bit is re-checked WCNT/2 cycles later (rejects glitches), then each data
// bit and the stop bit are sampled every WCNT cycles, i.e. near mid-bit.
// The byte/error pulse is registered on the stop-bit sample edge.

module uart_rx_byte
    import hex_rx_pkg::*;
#(
    parameter int WCNT = SERIAL_WCNT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rxd_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o,
    output rx_state_e  state_o
);

    localparam int CW = $clog2(WCNT + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(WCNT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(WCNT - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            prev_q;
    rx_state_e       state_q;
    logic [CW-1:0]   wcnt_q;
    logic [2:0]      bcnt_q;
    logic [7:0]      shreg_q;
    logic [7:0]      byte_q;
    logic            byte_valid_q;
    logic            frame_err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            prev_q       <= 1'b1;
            state_q      <= RX_IDLE;
            wcnt_q       <= '0;
            bcnt_q       <= 3'd0;
            shreg_q      <= 8'h00;
            byte_q       <= 8'h00;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync1_q      <= rxd_i;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    if (prev_q && !sync2_q) begin
                        state_q <= RX_START;
                        wcnt_q  <= '0;
                    end
                end
                RX_START: begin
                    if (wcnt_q == HALF_LAST) begin
                        wcnt_q <= '0;
                        bcnt_q <= 3'd0;
                        // Line back high at mid start bit: a glitch, not a frame.
                        state_q <= sync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        wcnt_q <= wcnt_q + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (wcnt_q == FULL_LAST) begin
                        wcnt_q  <= '0;
                        shreg_q <= {sync2_q, shreg_q[7:1]};
                        bcnt_q  <= bcnt_q + 3'd1;
                        if (bcnt_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end
                    end else begin
                        wcnt_q <= wcnt_q + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (wcnt_q == FULL_LAST) begin
                        wcnt_q  <= '0;
                        state_q <= RX_IDLE;
                        if (sync2_q) begin
                            byte_q       <= shreg_q;
                            byte_valid_q <= 1'b1;
                        end else begin
                            frame_err_q  <= 1'b1;
                        end
                    end else begin
                        wcnt_q <= wcnt_q + CW'(1);
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = byte_valid_q;
    assign frame_err_o  = frame_err_q;
    assign state_o      = state_q;

endmodule

// File: rtl/hex_rx.sv
// hex_rx -- receives ASCII hex digits over an 8N1 serial line and assembles
// them into a DIGIT*4-bit word.
//
// Ports:
//   CLK      clock, rising edge
//   RST      asynchronous active-high reset
//   RXD      serial line, idle high, 8N1, LSB first
//   RE       consumer read strobe
//   DATA     assembled word, last digit received in bits [3:0]
//   VALID    DATA holds an unread word
//   ERR      one-cycle pulse on framing error or illegal character
//   OVERRUN  one-cycle pulse when an unread word is overwritten
//
// Build option: HEX_RX_UPPER_EN enables upper-case 'A'-'F' digits.
//
// Output handshake: VALID rises on the edge that loads DATA and stays high
// until RE is sampled high, clearing on that edge. RE with VALID low does
// nothing. A load while VALID is high and RE is low replaces DATA and pulses
// OVERRUN; a load in the same cycle as RE is a clean hand-over (VALID stays
// high, no OVERRUN).
//
// Words: digits shift into an accumulator (older digits fall off the top once
// DIGIT digits are held). A terminator with at least one pending digit loads
// DATA; a terminator with none is ignored. Any other byte, or a framing
// error, pulses ERR and drops the pending digits without touching DATA/VALID.

module hex_rx
    import hex_rx_pkg::*;
#(
    parameter int DIGIT = 8,
    parameter int WCNT  = SERIAL_WCNT
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RXD,
    input  logic               RE,
    output logic [DIGIT*4-1:0] DATA,
    output logic               VALID,
    output logic               ERR,
    output logic               OVERRUN
);

    localparam int W   = DIGIT * 4;
    localparam int DCW = $clog2(DIGIT + 1);

    logic [7:0]     rx_byte;
    logic           rx_bvalid;
    logic           rx_ferr;
    // Deframer state is only observed hierarchically when debugging.
    rx_state_e      rx_state_unused;

    logic [W-1:0]   acc_q,     acc_d;
    logic [DCW-1:0] dcnt_q,    dcnt_d;
    logic [W-1:0]   data_q,    data_d;
    logic           valid_q,   valid_d;
    logic           err_q,     err_d;
    logic           overrun_q, overrun_d;
    logic           load;
    char_dec_t      dec;

    uart_rx_byte #(
        .WCNT(WCNT)
    ) u_rx (
        .clk_i       (CLK),
        .rst_i       (RST),
        .rxd_i       (RXD),
        .byte_o      (rx_byte),
        .byte_valid_o(rx_bvalid),
        .frame_err_o (rx_ferr),
        .state_o     (rx_state_unused)
    );

    always_comb begin
        acc_d     = acc_q;
        dcnt_d    = dcnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        err_d     = 1'b0;
        overrun_d = 1'b0;
        load      = 1'b0;
        dec       = decode_char(rx_byte);

        if (rx_ferr) begin
            acc_d  = '0;
            dcnt_d = '0;
            err_d  = 1'b1;
        end else if (rx_bvalid) begin
            case (dec.kind)
                CH_HEX: begin
                    acc_d = (acc_q << 4) | {{(W-4){1'b0}}, dec.nib};
                    if (dcnt_q != DCW'(DIGIT)) begin
                        dcnt_d = dcnt_q + DCW'(1);
                    end
                end
                CH_TERM: begin
                    load = (dcnt_q != '0);
                end
                default: begin
                    acc_d  = '0;
                    dcnt_d = '0;
                    err_d  = 1'b1;
                end
            endcase
        end

        // Unfilled upper digits are already zero: the accumulator is
        // cleared after every load or error.
        if (load) begin
            data_d    = acc_q;
            valid_d   = 1'b1;
            overrun_d = valid_q && !RE;
            acc_d     = '0;
            dcnt_d    = '0;
        end else if (RE) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc_q     <= '0;
            dcnt_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            dcnt_q    <= dcnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            overrun_q <= overrun_d;
        end
    end

    assign DATA    = data_q;
    assign VALID   = valid_q;
    assign ERR     = err_q;
    assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_hex_rx.sv
// tb_hex_rx -- self-checking bench for hex_rx (WCNT=8, DIGIT=8).

module tb_hex_rx;

    localparam int WCNT  = 8;
    localparam int DIGIT = 8;
    localparam int W     = DIGIT * 4;

    // ---------------- clock / reset ----------------
    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         RXD = 1'b1;
    logic         re_man = 1'b0;
    logic         RE;
    logic [W-1:0] DATA;
    logic         VALID;
    logic         ERR;
    logic         OVERRUN;

    assign RE = re_man;

    always #5 CLK = ~CLK;

    hex_rx #(
        .DIGIT(DIGIT),
        .WCNT (WCNT)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .RXD    (RXD),
        .RE     (RE),
        .DATA   (DATA),
        .VALID  (VALID),
        .ERR    (ERR),
        .OVERRUN(OVERRUN)
    );

    // ---------------- scoreboard state ----------------
    int           vectors     = 0;
    int           miscompares = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_w;

    // Event counters sampled on the falling edge.
    int   err_cnt    = 0;
    int   ov_cnt     = 0;
    int   load_cnt   = 0;
    logic valid_prev = 1'b0;

    always @(negedge CLK) begin
        if (RST) begin
            valid_prev = 1'b0;
        end else begin
            if (ERR)                err_cnt++;
            if (OVERRUN)            ov_cnt++;
            if (VALID && !valid_prev) load_cnt++;
            valid_prev = VALID;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge CLK);
        RXD = 1'b0;
        repeat (WCNT) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            repeat (WCNT) @(negedge CLK);
        end
        RXD = stop_bit;
        repeat (WCNT) @(negedge CLK);
        RXD = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], 1'b1);
        end
    endtask

    task automatic pulse_re();
        @(negedge CLK);
        re_man = 1'b1;
        @(negedge CLK);
        re_man = 1'b0;
    endtask

    // Pops and compares one expected word per VALID, reading each one.
    task automatic collect(input int budget);
        int t;
        t = 0;
        while (exp_q.size() > 0) begin
            @(negedge CLK);
            t++;
            if (VALID) begin
                exp_w = exp_q.pop_front();
                vectors++;
                if (DATA !== exp_w) begin
                    miscompares++;
                    $display("FAIL word: DATA=%h expected %h", DATA, exp_w);
                end
                re_man = 1'b1;
                @(negedge CLK);
                re_man = 1'b0;
            end
            if (t > budget) begin
                vectors++;
                miscompares++;
                $display("FAIL word_timeout: %0d word(s) pending, never became VALID", exp_q.size());
                exp_q.delete();
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        vectors++;
        if (DATA !== '0) begin miscompares++; $display("FAIL reset_data: DATA=%h expected 0", DATA); end
        vectors++;
        if (VALID !== 1'b0) begin miscompares++; $display("FAIL reset_valid: VALID=%b expected 0", VALID); end
        vectors++;
        if (ERR !== 1'b0) begin miscompares++; $display("FAIL reset_err: ERR=%b expected 0", ERR); end
        vectors++;
        if (OVERRUN !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: OVERRUN=%b expected 0", OVERRUN); end
        RST = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_basic();
        int e0, l0;
        e0 = err_cnt;
        l0 = load_cnt;
        exp_q.push_back(32'h00001a3f);
        fork
            begin send_str("1a3f"); send_byte(8'h0D, 1'b1); end
            collect(3000);
        join
        repeat (4) @(negedge CLK);
        vectors++;
        if (err_cnt - e0 != 0) begin miscompares++; $display("FAIL basic_err: %0d ERR pulses expected 0", err_cnt - e0); end
        vectors++;
        if (load_cnt - l0 != 1) begin miscompares++; $display("FAIL basic_loads: %0d loads expected 1", load_cnt - l0); end
    endtask

    task automatic test_overflow();
        exp_q.push_back(32'h23456789);
        fork
            send_str("123456789 ");
            collect(3000);
        join
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_framing();
        int e0;
        e0 = err_cnt;
        exp_q.push_back(32'h00000005);
        fork
            begin send_str("12"); send_byte(8'h33, 1'b0); send_str("5 "); end
            collect(3000);
        join
        repeat (4) @(negedge CLK);
        vectors++;
        if (err_cnt - e0 != 1) begin miscompares++; $display("FAIL framing_err: %0d ERR pulses expected 1", err_cnt - e0); end
    endtask

    task automatic test_illegal();
        int e0, l0;
        e0 = err_cnt;
        exp_q.push_back(32'h00000008);
        fork
            send_str("7g8\n");
            collect(3000);
        join
        repeat (4) @(negedge CLK);
        vectors++;
        if (err_cnt - e0 != 1) begin miscompares++; $display("FAIL illegal_g_err: %0d ERR pulses expected 1", err_cnt - e0); end

        e0 = err_cnt;
        l0 = load_cnt;
`ifdef HEX_RX_UPPER_EN
        exp_q.push_back(32'h000000ab);
`endif
        fork
            send_str("AB ");
            collect(3000);
        join
        repeat (4) @(negedge CLK);
`ifdef HEX_RX_UPPER_EN
        vectors++;
        if (err_cnt - e0 != 0) begin miscompares++; $display("FAIL upper_err: %0d ERR pulses expected 0", err_cnt - e0); end
        vectors++;
        if (load_cnt - l0 != 1) begin miscompares++; $display("FAIL upper_loads: %0d loads expected 1", load_cnt - l0); end
`else
        vectors++;
        if (err_cnt - e0 != 2) begin miscompares++; $display("FAIL upper_err: %0d ERR pulses expected 2", err_cnt - e0); end
        vectors++;
        if (load_cnt - l0 != 0) begin miscompares++; $display("FAIL upper_loads: %0d loads expected 0", load_cnt - l0); end
        vectors++;
        if (VALID !== 1'b0) begin miscompares++; $display("FAIL upper_valid: VALID=%b expected 0", VALID); end
`endif
    endtask

    task automatic test_overrun();
        int o0;
        // RE held low across two loads.
        o0 = ov_cnt;
        send_str("1 2 ");
        repeat (4) @(negedge CLK);
        vectors++;
        if (ov_cnt - o0 != 1) begin miscompares++; $display("FAIL overrun_cnt: %0d pulses expected 1", ov_cnt - o0); end
        vectors++;
        if (VALID !== 1'b1) begin miscompares++; $display("FAIL overrun_valid: VALID=%b expected 1", VALID); end
        vectors++;
        if (DATA !== 32'h00000002) begin miscompares++; $display("FAIL overrun_data: DATA=%h expected 00000002", DATA); end
        pulse_re();
        @(negedge CLK);
        vectors++;
        if (VALID !== 1'b0) begin miscompares++; $display("FAIL overrun_read: VALID=%b expected 0", VALID); end

        // RE coincides with the second load: stop sample lands 78 cycles
        // after the start-bit edge, the load one edge later.
        o0 = ov_cnt;
        send_str("1 2");
        fork
            send_byte(8'h20, 1'b1);
            begin
                @(negedge CLK);
                repeat (79) @(negedge CLK);
                re_man = 1'b1;
                @(negedge CLK);
                re_man = 1'b0;
            end
        join
        repeat (4) @(negedge CLK);
        vectors++;
        if (ov_cnt - o0 != 0) begin miscompares++; $display("FAIL handover_overrun: %0d pulses expected 0", ov_cnt - o0); end
        vectors++;
        if (VALID !== 1'b1) begin miscompares++; $display("FAIL handover_valid: VALID=%b expected 1", VALID); end
        vectors++;
        if (DATA !== 32'h00000002) begin miscompares++; $display("FAIL handover_data: DATA=%h expected 00000002", DATA); end
        pulse_re();
        @(negedge CLK);
    endtask

    task automatic test_reset_midframe();
        int e0;
        logic [7:0] b;
        b = 8'h39;
        // Leave an unread word and a pending digit before the reset.
        send_str("7 5");
        @(negedge CLK);
        RXD = 1'b0;
        repeat (WCNT) @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            RXD = b[i];
            repeat (WCNT) @(negedge CLK);
        end
        RXD = b[3];
        repeat (WCNT / 2) @(negedge CLK);
        RST = 1'b1;
        #1;
        vectors++;
        if (DATA !== '0) begin miscompares++; $display("FAIL midreset_data: DATA=%h expected 0", DATA); end
        vectors++;
        if (VALID !== 1'b0) begin miscompares++; $display("FAIL midreset_valid: VALID=%b expected 0", VALID); end
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        RXD = 1'b1;
        repeat (20) @(negedge CLK);
        e0 = err_cnt;
        exp_q.push_back(32'h00000003);
        fork
            send_str("3 ");
            collect(3000);
        join
        repeat (4) @(negedge CLK);
        vectors++;
        if (err_cnt - e0 != 0) begin miscompares++; $display("FAIL midreset_err: %0d ERR pulses expected 0", err_cnt - e0); end
    endtask

    task automatic test_glitch();
        int e0, l0;
        e0 = err_cnt;
        l0 = load_cnt;
        @(negedge CLK);
        RXD = 1'b0;
        repeat (2) @(negedge CLK);
        RXD = 1'b1;
        repeat (200) @(negedge CLK);
        // Read strobe with nothing pending.
        pulse_re();
        repeat (2) @(negedge CLK);
        vectors++;
        if (err_cnt - e0 != 0) begin miscompares++; $display("FAIL glitch_err: %0d ERR pulses expected 0", err_cnt - e0); end
        vectors++;
        if (load_cnt - l0 != 0) begin miscompares++; $display("FAIL glitch_loads: %0d loads expected 0", load_cnt - l0); end
        vectors++;
        if (VALID !== 1'b0) begin miscompares++; $display("FAIL glitch_valid: VALID=%b expected 0", VALID); end
        // Receiver must still frame normally afterwards.
        exp_q.push_back(32'h00000004);
        fork
            send_str("4 ");
            collect(3000);
        join
    endtask

    task automatic test_back_to_back();
        logic [7:0]   bq[$];
        logic [W-1:0] model;
        logic [7:0]   terms[3];
        int           n, d;
        terms[0] = 8'h20;
        terms[1] = 8'h0D;
        terms[2] = 8'h0A;
        for (int w = 0; w < 6; w++) begin
            n = $urandom_range(1, 10);
            model = '0;
            for (int k = 0; k < n; k++) begin
                d = $urandom_range(0, 15);
                model = (model << 4) | W'(d);
                bq.push_back(d < 10 ? 8'(8'h30 + d) : 8'(8'h61 + d - 10));
            end
            bq.push_back(terms[$urandom_range(0, 2)]);
            exp_q.push_back(model);
        end
        fork
            begin
                while (bq.size() > 0) send_byte(bq.pop_front(), 1'b1);
            end
            collect(9000);
        join
        repeat (4) @(negedge CLK);
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_framing();
        test_illegal();
        test_overrun();
        test_reset_midframe();
        test_glitch();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
